// File: rtl/udp_recv_if.sv
// udp_recv_if: payload byte stream leaving udp_recv.
// master drives o_data/o_data_vl/o_sof/o_eof, slave consumes them.
interface udp_recv_if;
  logic [7:0] o_data;
  logic       o_data_vl;
  logic       o_sof;
  logic       o_eof;

  modport master (
    output o_data,
    output o_data_vl,
    output o_sof,
    output o_eof
  );

  modport slave (
    input o_data,
    input o_data_vl,
    input o_sof,
    input o_eof
  );
endinterface

// File: rtl/udp_recv.sv
// udp_recv: GMII RX UDP/IPv4 parser; filters by MAC/type/proto/IP/port.
// Ports: rx byte stream in, payload stream out via pl, sender info, status.
module udp_recv #(
  parameter bit ACCEPT_BCAST = 1'b1
) (
  input  logic        rst_n,
  input  logic        i_rx_clk,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_dv,
  input  logic [47:0] i_my_mac,
  input  logic [31:0] i_my_ip,
  input  logic [15:0] i_my_port,
  udp_recv_if.master  pl,
  output logic [47:0] o_src_mac,
  output logic [31:0] o_src_ip,
  output logic [15:0] o_src_port,
  output logic [15:0] o_len,
  output logic        o_pkt_ok,
  output logic        o_pkt_drop,
  output logic        o_pkt_err,
  output logic [15:0] o_pkt_count
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, HDR, PAYLOAD, TRAILER, DROP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic        uc_q, uc_d;
  logic        bc_q, bc_d;
  logic        sync_q, sync_d;
  logic [47:0] smac_q, smac_d;
  logic [31:0] sip_q, sip_d;
  logic [15:0] sport_q, sport_d;
  logic [15:0] ulen_q, ulen_d;
  logic [7:0]  data_q, data_d;
  logic        vl_q, vl_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] len_q, len_d;
  logic        ok_q, ok_d;
  logic        drop_q, drop_d;
  logic        err_q, err_d;
  logic [15:0] pkt_count_q, pkt_count_d;

  logic [7:0]  mac_b, ip_b, port_b;
  logic        bad;

  always_comb begin
    case (n_q[2:0])
      3'd0:    mac_b = i_my_mac[47:40];
      3'd1:    mac_b = i_my_mac[39:32];
      3'd2:    mac_b = i_my_mac[31:24];
      3'd3:    mac_b = i_my_mac[23:16];
      3'd4:    mac_b = i_my_mac[15:8];
      default: mac_b = i_my_mac[7:0];
    endcase
    // dst IP sits at n=30..33, so n[1:0] runs 2,3,0,1
    case (n_q[1:0])
      2'd2:    ip_b = i_my_ip[31:24];
      2'd3:    ip_b = i_my_ip[23:16];
      2'd0:    ip_b = i_my_ip[15:8];
      default: ip_b = i_my_ip[7:0];
    endcase
    port_b = n_q[0] ? i_my_port[7:0] : i_my_port[15:8];
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    uc_d        = uc_q;
    bc_d        = bc_q;
    // armed once dv has been seen low; blocks mid-frame pickup
    sync_d      = sync_q | ~i_rx_dv;
    smac_d      = smac_q;
    sip_d       = sip_q;
    sport_d     = sport_q;
    ulen_d      = ulen_q;
    data_d      = 8'h00;
    vl_d        = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    src_mac_d   = src_mac_q;
    src_ip_d    = src_ip_q;
    src_port_d  = src_port_q;
    len_d       = len_q;
    ok_d        = 1'b0;
    drop_d      = 1'b0;
    err_d       = 1'b0;
    pkt_count_d = pkt_count_q;
    bad         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_rx_dv && sync_q) begin
          state_d = (i_rx_data == 8'h55) ? PREAMBLE : DROP;
        end
      end
      PREAMBLE: begin
        if (!i_rx_dv) begin
          state_d = IDLE;
        end else if (i_rx_data == 8'hD5) begin
          state_d = HDR;
          n_d     = 16'd0;
          uc_d    = 1'b1;
          bc_d    = 1'b1;
        end else if (i_rx_data != 8'h55) begin
          state_d = DROP;
        end
      end
      HDR: begin
        n_d = n_q + 16'd1;
        if (!i_rx_dv) begin
          drop_d  = 1'b1;
          state_d = IDLE;
        end else begin
          unique case (1'b1)
            (n_q < 16'd6): begin
              uc_d = uc_q & (i_rx_data == mac_b);
              bc_d = bc_q & (i_rx_data == 8'hFF);
              // MAC verdict taken once all six bytes are in
              if (n_q == 16'd5)
                bad = !(uc_d || (ACCEPT_BCAST && bc_d));
            end
            (n_q >= 16'd6 && n_q < 16'd12):
              smac_d = {smac_q[39:0], i_rx_data};
            (n_q == 16'd12): bad = (i_rx_data != 8'h08);
            (n_q == 16'd13): bad = (i_rx_data != 8'h00);
            (n_q == 16'd14): bad = (i_rx_data != 8'h45);
            (n_q == 16'd23): bad = (i_rx_data != 8'h11);
            (n_q >= 16'd26 && n_q < 16'd30):
              sip_d = {sip_q[23:0], i_rx_data};
            (n_q >= 16'd30 && n_q < 16'd34):
              bad = (i_rx_data != ip_b);
            (n_q == 16'd34 || n_q == 16'd35):
              sport_d = {sport_q[7:0], i_rx_data};
            (n_q == 16'd36 || n_q == 16'd37):
              bad = (i_rx_data != port_b);
            (n_q == 16'd38):
              ulen_d = {ulen_q[7:0], i_rx_data};
            (n_q == 16'd39): begin
              ulen_d = {ulen_q[7:0], i_rx_data};
              bad    = (ulen_d < 16'd8);
            end
            (n_q == 16'd41): begin
              src_mac_d  = smac_q;
              src_ip_d   = sip_q;
              src_port_d = sport_q;
              len_d      = ulen_q - 16'd8;
              n_d        = 16'd0;
              if (ulen_q == 16'd8) begin
                ok_d        = 1'b1;
                pkt_count_d = pkt_count_q + 16'd1;
                state_d     = TRAILER;
              end else begin
                state_d = PAYLOAD;
              end
            end
            default: ;
          endcase
          if (bad) begin
            drop_d  = 1'b1;
            state_d = DROP;
          end
        end
      end
      PAYLOAD: begin
        if (!i_rx_dv) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          data_d = i_rx_data;
          vl_d   = 1'b1;
          sof_d  = (n_q == 16'd0);
          n_d    = n_q + 16'd1;
          if (n_d == len_q) begin
            eof_d       = 1'b1;
            ok_d        = 1'b1;
            pkt_count_d = pkt_count_q + 16'd1;
            state_d     = TRAILER;
          end
        end
      end
      TRAILER, DROP: begin
        if (!i_rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= 16'd0;
      uc_q        <= 1'b0;
      bc_q        <= 1'b0;
      sync_q      <= 1'b0;
      smac_q      <= 48'd0;
      sip_q       <= 32'd0;
      sport_q     <= 16'd0;
      ulen_q      <= 16'd0;
      data_q      <= 8'h00;
      vl_q        <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      src_mac_q   <= 48'd0;
      src_ip_q    <= 32'd0;
      src_port_q  <= 16'd0;
      len_q       <= 16'd0;
      ok_q        <= 1'b0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
      pkt_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      uc_q        <= uc_d;
      bc_q        <= bc_d;
      sync_q      <= sync_d;
      smac_q      <= smac_d;
      sip_q       <= sip_d;
      sport_q     <= sport_d;
      ulen_q      <= ulen_d;
      data_q      <= data_d;
      vl_q        <= vl_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      src_mac_q   <= src_mac_d;
      src_ip_q    <= src_ip_d;
      src_port_q  <= src_port_d;
      len_q       <= len_d;
      ok_q        <= ok_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pl.o_data    = data_q;
  assign pl.o_data_vl = vl_q;
  assign pl.o_sof     = sof_q;
  assign pl.o_eof     = eof_q;
  assign o_src_mac    = src_mac_q;
  assign o_src_ip     = src_ip_q;
  assign o_src_port   = src_port_q;
  assign o_len        = len_q;
  assign o_pkt_ok     = ok_q;
  assign o_pkt_drop   = drop_q;
  assign o_pkt_err    = err_q;
  assign o_pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_udp_recv.sv
// tb_udp_recv: directed frames into two udp_recv instances
// (broadcast accepted / rejected) with inline expected values.
module tb_udp_recv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_dv = 1'b0;
  logic [47:0] my_mac = 48'h000A35010203;
  logic [31:0] my_ip = 32'h0A000064;
  logic [15:0] my_port = 16'd5152;

  logic [47:0] a_smac, b_smac;
  logic [31:0] a_sip, b_sip;
  logic [15:0] a_sport, b_sport, a_len, b_len, a_cnt, b_cnt;
  logic        a_ok, a_drop, a_err, b_ok, b_drop, b_err;

  udp_recv_if pa();
  udp_recv_if pb();

  udp_recv #(.ACCEPT_BCAST(1'b1)) dut_a (
    .rst_n(rst_n), .i_rx_clk(clk),
    .i_rx_data(rx_data), .i_rx_dv(rx_dv),
    .i_my_mac(my_mac), .i_my_ip(my_ip), .i_my_port(my_port),
    .pl(pa),
    .o_src_mac(a_smac), .o_src_ip(a_sip), .o_src_port(a_sport),
    .o_len(a_len), .o_pkt_ok(a_ok), .o_pkt_drop(a_drop),
    .o_pkt_err(a_err), .o_pkt_count(a_cnt)
  );

  udp_recv #(.ACCEPT_BCAST(1'b0)) dut_b (
    .rst_n(rst_n), .i_rx_clk(clk),
    .i_rx_data(rx_data), .i_rx_dv(rx_dv),
    .i_my_mac(my_mac), .i_my_ip(my_ip), .i_my_port(my_port),
    .pl(pb),
    .o_src_mac(b_smac), .o_src_ip(b_sip), .o_src_port(b_sport),
    .o_len(b_len), .o_pkt_ok(b_ok), .o_pkt_drop(b_drop),
    .o_pkt_err(b_err), .o_pkt_count(b_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  int nbytes, sof_cnt, sof_idx, eof_cnt, eof_ok;
  int ok_cnt, drop_cnt, err_cnt, ok_cyc, drop_cyc, err_cyc;
  int drop_b, drop_b_cyc, b_vl;
  int excl_bad = 0;
  logic [15:0] len_at_sof;
  logic [7:0]  eof_data;
  logic [7:0]  rxb[$];
  logic [7:0]  frm[$];
  int          bcyc[0:127];
  int          dvlow_cyc;

  always @(negedge clk) begin
    if (pa.o_data_vl) begin
      rxb.push_back(pa.o_data);
      if (pa.o_sof) begin
        sof_cnt++;
        sof_idx = nbytes;
        len_at_sof = a_len;
      end
      if (pa.o_eof) begin
        eof_cnt++;
        eof_data = pa.o_data;
        if (a_ok) eof_ok++;
      end
      nbytes++;
    end
    if (a_ok) begin ok_cnt++; ok_cyc = cyc; end
    if (a_drop) begin drop_cnt++; drop_cyc = cyc; end
    if (a_err) begin err_cnt++; err_cyc = cyc; end
    if (b_drop) begin drop_b++; drop_b_cyc = cyc; end
    if (pb.o_data_vl) b_vl++;
    if (int'(a_ok) + int'(a_drop) + int'(a_err) > 1) excl_bad++;
    if (int'(b_ok) + int'(b_drop) + int'(b_err) > 1) excl_bad++;
  end

  task automatic clr();
    nbytes = 0; sof_cnt = 0; sof_idx = -1; eof_cnt = 0; eof_ok = 0;
    ok_cnt = 0; drop_cnt = 0; err_cnt = 0;
    ok_cyc = -1; drop_cyc = -1; err_cyc = -1;
    drop_b = 0; drop_b_cyc = -1; b_vl = 0;
    len_at_sof = 16'hDEAD; eof_data = 8'h00;
    rxb.delete();
  endtask

  task automatic push_be(input logic [47:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] et,
                       input logic [15:0] dport, input logic [15:0] ulen,
                       input int npay, input int npad);
    logic [15:0] tl;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    push_be(dst, 6);
    push_be(48'h0023543C471B, 6);
    push_be({32'd0, et}, 2);
    tl = 16'd28 + 16'(npay);
    push_be({40'd0, 8'h45}, 1);
    push_be({40'd0, 8'h00}, 1);
    push_be({32'd0, tl}, 2);
    push_be(48'h000040004011, 6);
    push_be(48'h0, 2);
    push_be({16'd0, 32'h0A000002}, 4);
    push_be({16'd0, 32'h0A000064}, 4);
    push_be({32'd0, 16'd2179}, 2);
    push_be({32'd0, dport}, 2);
    push_be({32'd0, ulen}, 2);
    push_be(48'h0, 2);
    for (int i = 0; i < npay; i++) frm.push_back(8'(i + 1));
    for (int i = 0; i < npad; i++) frm.push_back(8'h00);
    push_be({16'd0, 32'hDEADBEEF}, 4);
  endtask

  task automatic send(input int upto);
    for (int i = 0; i < frm.size() && i < upto; i++) begin
      @(negedge clk);
      rx_data = frm[i];
      rx_dv = 1'b1;
      bcyc[i] = cyc;
    end
    @(negedge clk);
    rx_dv = 1'b0;
    rx_data = 8'h00;
    dvlow_cyc = cyc;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (pa.o_data_vl !== 1'b0) begin errors++; $display("FAIL rst_vl: got %b want 0", pa.o_data_vl); end
    checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", a_cnt); end
    checks++; if ({a_ok, a_drop, a_err} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b want 000", {a_ok, a_drop, a_err}); end
    checks++; if ({a_len, a_sip} !== 48'd0) begin errors++; $display("FAIL rst_len_ip: got %h want 0", {a_len, a_sip}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_unicast(input logic [15:0] exp_cnt);
    logic [31:0] pay;
    clr();
    build(my_mac, 16'h0800, 16'd5152, 16'h000C, 4, 0);
    send(1000);
    pay = 32'hx;
    if (rxb.size() >= 4) pay = {rxb[0], rxb[1], rxb[2], rxb[3]};
    checks++; if (nbytes !== 4) begin errors++; $display("FAIL uc_nbytes: got %0d want 4", nbytes); end
    checks++; if (pay !== 32'h01020304) begin errors++; $display("FAIL uc_payload: got %h want 01020304", pay); end
    checks++; if (sof_cnt !== 1 || sof_idx !== 0) begin errors++; $display("FAIL uc_sof: got cnt %0d idx %0d want 1 0", sof_cnt, sof_idx); end
    checks++; if (eof_cnt !== 1 || eof_ok !== 1 || eof_data !== 8'h04) begin errors++; $display("FAIL uc_eof: got %0d %0d %h want 1 1 04", eof_cnt, eof_ok, eof_data); end
    checks++; if (ok_cnt !== 1 || drop_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL uc_pulses: got %0d %0d %0d want 1 0 0", ok_cnt, drop_cnt, err_cnt); end
    checks++; if (len_at_sof !== 16'd4 || a_len !== 16'd4) begin errors++; $display("FAIL uc_len: got %0d/%0d want 4", len_at_sof, a_len); end
    checks++; if (a_sip !== 32'h0A000002) begin errors++; $display("FAIL uc_src_ip: got %h want 0a000002", a_sip); end
    checks++; if (a_sport !== 16'd2179) begin errors++; $display("FAIL uc_src_port: got %0d want 2179", a_sport); end
    checks++; if (a_smac !== 48'h0023543C471B) begin errors++; $display("FAIL uc_src_mac: got %h want 0023543c471b", a_smac); end
    checks++; if (a_cnt !== exp_cnt) begin errors++; $display("FAIL uc_count: got %0d want %0d", a_cnt, exp_cnt); end
  endtask

  task automatic test_wrong_dest(input logic [15:0] et, input logic [15:0] dport,
                                 input logic [15:0] exp_cnt);
    clr();
    build(my_mac, et, dport, 16'h000C, 4, 0);
    send(1000);
    checks++; if (drop_cnt !== 1 || ok_cnt !== 0) begin errors++; $display("FAIL wd_drop: got drop %0d ok %0d want 1 0 (et %h port %0d)", drop_cnt, ok_cnt, et, dport); end
    checks++; if (nbytes !== 0) begin errors++; $display("FAIL wd_data: got %0d bytes want 0", nbytes); end
    checks++; if (a_cnt !== exp_cnt) begin errors++; $display("FAIL wd_count: got %0d want %0d", a_cnt, exp_cnt); end
  endtask

  task automatic test_bcast();
    clr();
    build(48'hFFFFFFFFFFFF, 16'h0800, 16'd5152, 16'h000C, 4, 0);
    send(1000);
    checks++; if (ok_cnt !== 1 || nbytes !== 4) begin errors++; $display("FAIL bc_accept: got ok %0d bytes %0d want 1 4", ok_cnt, nbytes); end
    checks++; if (a_cnt !== 16'd2) begin errors++; $display("FAIL bc_count: got %0d want 2", a_cnt); end
    checks++; if (drop_b !== 1 || b_vl !== 0) begin errors++; $display("FAIL bc_nobcast_drop: got drop %0d vl %0d want 1 0", drop_b, b_vl); end
    checks++; if (drop_b_cyc !== bcyc[13] + 1) begin errors++; $display("FAIL bc_drop_time: got %0d want %0d", drop_b_cyc, bcyc[13] + 1); end
  endtask

  task automatic test_truncation();
    clr();
    build(my_mac, 16'h0800, 16'd5152, 16'h000C, 4, 0);
    send(52);
    checks++; if (nbytes !== 2 || eof_cnt !== 0) begin errors++; $display("FAIL tr_data: got %0d bytes %0d eof want 2 0", nbytes, eof_cnt); end
    checks++; if (err_cnt !== 1 || ok_cnt !== 0 || drop_cnt !== 0) begin errors++; $display("FAIL tr_pulses: got err %0d ok %0d drop %0d want 1 0 0", err_cnt, ok_cnt, drop_cnt); end
    checks++; if (err_cyc !== dvlow_cyc + 1) begin errors++; $display("FAIL tr_err_time: got %0d want %0d", err_cyc, dvlow_cyc + 1); end
    checks++; if (a_cnt !== 16'd2) begin errors++; $display("FAIL tr_count: got %0d want 2", a_cnt); end
    test_unicast(16'd3);
  endtask

  task automatic test_zero_len();
    clr();
    build(my_mac, 16'h0800, 16'd5152, 16'h0008, 0, 18);
    send(1000);
    checks++; if (ok_cnt !== 1 || nbytes !== 0) begin errors++; $display("FAIL zl_ok: got ok %0d bytes %0d want 1 0", ok_cnt, nbytes); end
    checks++; if (a_len !== 16'd0 || a_cnt !== 16'd4) begin errors++; $display("FAIL zl_len_cnt: got %0d %0d want 0 4", a_len, a_cnt); end
    checks++; if (ok_cyc !== bcyc[49] + 1) begin errors++; $display("FAIL zl_ok_time: got %0d want %0d", ok_cyc, bcyc[49] + 1); end
    clr();
    build(my_mac, 16'h0800, 16'd5152, 16'h0004, 0, 18);
    send(1000);
    checks++; if (drop_cnt !== 1 || ok_cnt !== 0) begin errors++; $display("FAIL ul4_drop: got drop %0d ok %0d want 1 0", drop_cnt, ok_cnt); end
    checks++; if (drop_cyc !== bcyc[47] + 1) begin errors++; $display("FAIL ul4_drop_time: got %0d want %0d", drop_cyc, bcyc[47] + 1); end
    checks++; if (a_cnt !== 16'd4) begin errors++; $display("FAIL ul4_count: got %0d want 4", a_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] embed[$];
    build(my_mac, 16'h0800, 16'd5152, 16'h000C, 4, 0);
    embed = frm;
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk);
      rx_data = frm[i];
      rx_dv = 1'b1;
      if (i == 52) rst_n = 1'b0;
      if (i == 53) begin
        checks++; if (pa.o_data_vl !== 1'b0 || a_cnt !== 16'd0 || a_len !== 16'd0) begin errors++; $display("FAIL rm_zero: got vl %b cnt %0d len %0d want 0 0 0", pa.o_data_vl, a_cnt, a_len); end
      end
    end
    clr();
    rst_n = 1'b1;
    // a complete frame back-to-back with no dv gap must be ignored
    for (int i = 0; i < embed.size(); i++) begin
      rx_data = embed[i];
      @(negedge clk);
    end
    rx_dv = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ok_cnt !== 0 || nbytes !== 0 || drop_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL rm_resync: got ok %0d bytes %0d drop %0d err %0d want 0", ok_cnt, nbytes, drop_cnt, err_cnt); end
    test_unicast(16'd1);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut_a.pkt_count_q = 16'hFFFF;
    @(negedge clk);
    release dut_a.pkt_count_q;
    repeat (2) @(negedge clk);
    clr();
    build(my_mac, 16'h0800, 16'd5152, 16'h000C, 4, 0);
    send(1000);
    checks++; if (ok_cnt !== 1 || a_cnt !== 16'd0) begin errors++; $display("FAIL wrap: got ok %0d cnt %0d want 1 0", ok_cnt, a_cnt); end
  endtask

  task automatic test_exclusive();
    checks++; if (excl_bad !== 0) begin errors++; $display("FAIL exclusive: got %0d overlaps want 0", excl_bad); end
  endtask

  initial begin
    clr();
    test_reset();
    test_unicast(16'd1);
    test_wrong_dest(16'h0800, 16'd5153, 16'd1);
    test_wrong_dest(16'h0806, 16'd5152, 16'd1);
    test_bcast();
    test_truncation();
    test_zero_len();
    test_reset_mid();
    test_wrap();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
